// File: rtl/wb_arbiter.sv
// wb_arbiter: per-source result FIFOs feeding NR_WB_PORTS scoreboard write-back ports through a round-robin grant.
// Optional macro WB_ARBITER_BYPASS_EN lets an empty source with a fresh result win arbitration in the same cycle.
`default_nettype none

module wb_arbiter #(
    parameter int NR_SRC        = 4,
    parameter int NR_WB_PORTS   = 2,
    parameter int DEPTH         = 2,
    parameter int XLEN          = 64,
    parameter int TRANS_ID_BITS = 3,
    parameter int EXC_BITS      = 8
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    input  logic                                        flush_i,
    input  logic [NR_SRC-1:0]                           src_valid_i,
    input  logic [NR_SRC-1:0][XLEN-1:0]                 src_result_i,
    input  logic [NR_SRC-1:0][TRANS_ID_BITS-1:0]        src_trans_id_i,
    input  logic [NR_SRC-1:0][EXC_BITS-1:0]             src_exception_i,
    output logic [NR_SRC-1:0]                           src_almost_full_o,
    output logic [NR_WB_PORTS-1:0]                      wb_valid_o,
    output logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]   wb_trans_id_o,
    output logic [NR_WB_PORTS-1:0][XLEN-1:0]            wb_result_o,
    output logic [NR_WB_PORTS-1:0][EXC_BITS-1:0]        wb_exception_o,
    output logic                                        overflow_o
);

    localparam int SRC_W   = (NR_SRC > 1) ? $clog2(NR_SRC) : 1;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = XLEN + TRANS_ID_BITS + EXC_BITS;

    typedef logic [ENTRY_W-1:0] entry_t;

    logic [NR_SRC-1:0] empty;
    logic [NR_SRC-1:0] full;
    logic [NR_SRC-1:0] cand;
    logic [NR_SRC-1:0] grant;
    logic [NR_SRC-1:0] pop;
    logic [NR_SRC-1:0] push;
    logic [NR_SRC-1:0] drop;
    logic [NR_SRC-1:0] wr_en;
    entry_t            head      [NR_SRC];
    entry_t            src_entry [NR_SRC];

    logic [SRC_W-1:0]  rr_q;
    logic [SRC_W-1:0]  rr_d;
    logic              overflow_q;

    for (genvar s = 0; s < NR_SRC; s++) begin : g_src
        logic [PTR_W-1:0] rd_ptr;
        logic [PTR_W-1:0] wr_ptr;
        logic [CNT_W-1:0] count;
        entry_t           mem [DEPTH];

        assign src_entry[s]         = {src_result_i[s], src_trans_id_i[s], src_exception_i[s]};
        assign empty[s]             = (count == '0);
        assign full[s]              = (count == CNT_W'(DEPTH));
        assign src_almost_full_o[s] = (count >= CNT_W'(DEPTH - 1));
        assign head[s]              = mem[rd_ptr];

`ifdef WB_ARBITER_BYPASS_EN
        // An empty source presenting a result competes directly; if it wins, nothing is stored.
        assign cand[s] = !flush_i && (!empty[s] || src_valid_i[s]);
        assign push[s] = src_valid_i[s] && !flush_i && !(grant[s] && empty[s]);
`else
        assign cand[s] = !flush_i && !empty[s];
        assign push[s] = src_valid_i[s] && !flush_i;
`endif

        assign pop[s]   = grant[s] && !empty[s];
        // A full FIFO still takes a push when its head leaves in the same cycle.
        assign drop[s]  = push[s] && full[s] && !pop[s];
        assign wr_en[s] = push[s] && !drop[s];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else if (flush_i) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (wr_en[s]) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop[s])   rd_ptr <= rd_ptr + PTR_W'(1);
                count <= count + CNT_W'(wr_en[s]) - CNT_W'(pop[s]);
            end
        end

        always_ff @(posedge clk_i) begin
            if (wr_en[s]) mem[wr_ptr] <= src_entry[s];
        end
    end

    // Scan from rr_q upward; the k-th winner drives port k.
    always_comb begin
        int     k;
        int     idx;
        int     last;
        entry_t sel;
        grant          = '0;
        wb_valid_o     = '0;
        wb_trans_id_o  = '0;
        wb_result_o    = '0;
        wb_exception_o = '0;
        rr_d           = rr_q;
        k              = 0;
        idx            = 0;
        last           = 0;
        sel            = '0;
        for (int i = 0; i < NR_SRC; i++) begin
            idx = (int'(rr_q) + i) % NR_SRC;
            if (cand[idx] && (k < NR_WB_PORTS)) begin
                sel        = empty[idx] ? src_entry[idx] : head[idx];
                grant[idx] = 1'b1;
                wb_valid_o[k] = 1'b1;
                {wb_result_o[k], wb_trans_id_o[k], wb_exception_o[k]} = sel;
                k    = k + 1;
                last = idx;
            end
        end
        if (k > 0) begin
            rr_d = (last == NR_SRC - 1) ? '0 : SRC_W'(last + 1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q       <= '0;
            overflow_q <= 1'b0;
        end else begin
            rr_q <= flush_i ? '0 : rr_d;
            if (|drop) overflow_q <= 1'b1;
        end
    end

    assign overflow_o = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed table-driven checks of wb_arbiter plus hand-written reset, flush and latency sequences.
`default_nettype none

module tb_wb_arbiter;

    localparam int NS = 4;
    localparam int NP = 2;
    localparam int XL = 64;
    localparam int TB = 3;
    localparam int EB = 8;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   flush;
    logic [NS-1:0]          valid;
    logic [NS-1:0][XL-1:0]  res;
    logic [NS-1:0][TB-1:0]  tid;
    logic [NS-1:0][EB-1:0]  exc;
    logic [NS-1:0]          af;
    logic [NP-1:0]          wb_valid;
    logic [NP-1:0][TB-1:0]  wb_tid;
    logic [NP-1:0][XL-1:0]  wb_res;
    logic [NP-1:0][EB-1:0]  wb_exc;
    logic                   ovf;

    int total = 0;
    int passed = 0;

    wb_arbiter #(
        .NR_SRC(NS), .NR_WB_PORTS(NP), .DEPTH(2), .XLEN(XL), .TRANS_ID_BITS(TB), .EXC_BITS(EB)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .flush_i(flush),
        .src_valid_i(valid),
        .src_result_i(res),
        .src_trans_id_i(tid),
        .src_exception_i(exc),
        .src_almost_full_o(af),
        .wb_valid_o(wb_valid),
        .wb_trans_id_o(wb_tid),
        .wb_result_o(wb_res),
        .wb_exception_o(wb_exc),
        .overflow_o(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fl;
        logic [3:0]  val;
        logic [11:0] tids;
        logic [1:0]  ev;
        int          s0;
        logic [2:0]  t0;
        int          s1;
        logic [2:0]  t1;
        logic [3:0]  eaf;
        logic        eovf;
    } vec_t;

    function automatic vec_t mk(input logic fl, input logic [3:0] val, input logic [11:0] tids,
                                input logic [1:0] ev, input int s0, input logic [2:0] t0,
                                input int s1, input logic [2:0] t1, input logic [3:0] eaf,
                                input logic eovf);
        vec_t v;
        v.fl = fl; v.val = val; v.tids = tids; v.ev = ev;
        v.s0 = s0; v.t0 = t0; v.s1 = s1; v.t1 = t1; v.eaf = eaf; v.eovf = eovf;
        return v;
    endfunction

    function automatic logic [XL-1:0] res_of(input int s, input logic [2:0] t);
        return 64'hC0DE_0000_0000_0000 | (64'(s) << 8) | 64'(t);
    endfunction

    function automatic logic [EB-1:0] exc_of(input int s, input logic [2:0] t);
        return 8'(s * 16 + int'(t));
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else passed++;
    endtask

    task automatic chk_port(input string nm, input int p, input int s, input logic [2:0] t);
        chk({nm, ".tid"}, 64'(wb_tid[p]), (s < 0) ? 64'd0 : 64'(t));
        chk({nm, ".res"}, wb_res[p],      (s < 0) ? 64'd0 : res_of(s, t));
        chk({nm, ".exc"}, 64'(wb_exc[p]), (s < 0) ? 64'd0 : 64'(exc_of(s, t)));
    endtask

    task automatic drive(input logic fl, input logic [3:0] val, input logic [11:0] tids);
        flush = fl;
        valid = val;
        for (int s = 0; s < NS; s++) begin
            tid[s] = tids[s*3 +: 3];
            res[s] = res_of(s, tid[s]);
            exc[s] = exc_of(s, tid[s]);
        end
    endtask

    vec_t vecs[19];

    initial begin
        // Inputs apply just after the rising edge; outputs are sampled on the falling edge.
        vecs[0]  = mk(1, 4'b0000, 12'd0, 2'b00, -1, 0, -1, 0, 4'b0000, 0);
        vecs[1]  = mk(0, 4'b1111, {3'd6, 3'd4, 3'd2, 3'd1}, 2'b00, -1, 0, -1, 0, 4'b0000, 0);
        vecs[2]  = mk(0, 4'b0000, 12'd0, 2'b11, 0, 1, 1, 2, 4'b1111, 0);
        vecs[3]  = mk(0, 4'b0000, 12'd0, 2'b11, 2, 4, 3, 6, 4'b1100, 0);
        vecs[4]  = mk(0, 4'b0000, 12'd0, 2'b00, -1, 0, -1, 0, 4'b0000, 0);
        vecs[5]  = mk(0, 4'b1101, {3'd3, 3'd2, 3'd0, 3'd1}, 2'b00, -1, 0, -1, 0, 4'b0000, 0);
        vecs[6]  = mk(0, 4'b0011, {3'd0, 3'd0, 3'd4, 3'd5}, 2'b11, 0, 1, 2, 2, 4'b1101, 0);
        vecs[7]  = mk(0, 4'b0110, {3'd0, 3'd7, 3'd6, 3'd0}, 2'b11, 3, 3, 0, 5, 4'b1011, 0);
        vecs[8]  = mk(0, 4'b1011, {3'd1, 3'd0, 3'd0, 3'd2}, 2'b11, 1, 4, 2, 7, 4'b0110, 0);
        vecs[9]  = mk(0, 4'b0010, {3'd0, 3'd0, 3'd3, 3'd0}, 2'b11, 3, 1, 0, 2, 4'b1011, 0);
        vecs[10] = mk(0, 4'b0000, 12'd0, 2'b01, 1, 6, -1, 0, 4'b0010, 1);
        vecs[11] = mk(0, 4'b0000, 12'd0, 2'b01, 1, 0, -1, 0, 4'b0010, 1);
        vecs[12] = mk(0, 4'b0000, 12'd0, 2'b00, -1, 0, -1, 0, 4'b0000, 1);
        vecs[13] = mk(0, 4'b1100, {3'd5, 3'd4, 3'd0, 3'd0}, 2'b00, -1, 0, -1, 0, 4'b0000, 1);
        vecs[14] = mk(1, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd6}, 2'b00, -1, 0, -1, 0, 4'b1100, 1);
        vecs[15] = mk(0, 4'b0000, 12'd0, 2'b00, -1, 0, -1, 0, 4'b0000, 1);
        vecs[16] = mk(0, 4'b0010, {3'd0, 3'd0, 3'd5, 3'd0}, 2'b00, -1, 0, -1, 0, 4'b0000, 1);
        vecs[17] = mk(0, 4'b0000, 12'd0, 2'b01, 1, 5, -1, 0, 4'b0010, 1);
        vecs[18] = mk(0, 4'b0000, 12'd0, 2'b00, -1, 0, -1, 0, 4'b0000, 1);

        rst_n = 1'b0;
        drive(0, 4'b0000, 12'd0);
        #2;
        chk("reset.valid", 64'(wb_valid), 64'd0);
        chk("reset.af",    64'(af),       64'd0);
        chk("reset.ovf",   64'(ovf),      64'd0);
        chk_port("reset.p0", 0, -1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single FLU result with a distinctive payload.
        valid = 4'b0001; tid[0] = 3'd3; res[0] = 64'hDEAD; exc[0] = '0;
        @(negedge clk);
`ifdef WB_ARBITER_BYPASS_EN
        chk("flu.same_cycle.valid", 64'(wb_valid), 64'b01);
`else
        chk("flu.same_cycle.valid", 64'(wb_valid), 64'b00);
`endif
        @(posedge clk); #1;
        valid = '0;
        @(negedge clk);
`ifdef WB_ARBITER_BYPASS_EN
        chk("flu.next.valid", 64'(wb_valid), 64'b00);
`else
        chk("flu.next.valid", 64'(wb_valid), 64'b01);
        chk("flu.next.tid",   64'(wb_tid[0]), 64'd3);
        chk("flu.next.res",   wb_res[0],      64'hDEAD);
        chk("flu.next.af",    64'(af),        64'b0001);
`endif
        @(posedge clk); #1;
        @(negedge clk);
        chk("flu.after.valid", 64'(wb_valid), 64'b00);
        @(posedge clk); #1;

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].fl, vecs[i].val, vecs[i].tids);
            @(negedge clk);
            chk($sformatf("v%0d.valid", i), 64'(wb_valid), 64'(vecs[i].ev));
            chk_port($sformatf("v%0d.p0", i), 0, vecs[i].s0, vecs[i].t0);
            chk_port($sformatf("v%0d.p1", i), 1, vecs[i].s1, vecs[i].t1);
            chk($sformatf("v%0d.af", i),  64'(af),  64'(vecs[i].eaf));
            chk($sformatf("v%0d.ovf", i), 64'(ovf), 64'(vecs[i].eovf));
            @(posedge clk); #1;
        end
        drive(0, 4'b0000, 12'd0);

        // Reset in the middle of buffered traffic.
        drive(0, 4'b0011, {3'd0, 3'd0, 3'd2, 3'd1});
        @(posedge clk); #1;
        drive(0, 4'b0000, 12'd0);
        @(negedge clk);
        chk("midrst.before.valid", 64'(wb_valid), 64'b11);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst.valid", 64'(wb_valid), 64'd0);
        chk("midrst.af",    64'(af),       64'd0);
        chk("midrst.ovf",   64'(ovf),      64'd0);
        chk_port("midrst.p0", 0, -1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst.after.valid", 64'(wb_valid), 64'd0);
        @(posedge clk); #1;

        // FPU result into an idle arbiter.
        drive(0, 4'b1000, {3'd7, 3'd0, 3'd0, 3'd0});
        @(negedge clk);
`ifdef WB_ARBITER_BYPASS_EN
        chk("fpu.same.valid", 64'(wb_valid), 64'b01);
        chk_port("fpu.same.p0", 0, 3, 3'd7);
`else
        chk("fpu.same.valid", 64'(wb_valid), 64'b00);
`endif
        @(posedge clk); #1;
        drive(0, 4'b0000, 12'd0);
        @(negedge clk);
`ifdef WB_ARBITER_BYPASS_EN
        chk("fpu.next.valid", 64'(wb_valid), 64'b00);
        chk("fpu.next.af",    64'(af),       64'b0000);
`else
        chk("fpu.next.valid", 64'(wb_valid), 64'b01);
        chk_port("fpu.next.p0", 0, 3, 3'd7);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter NR_SRC, default 4, number of result sources (0=FLU, 1=load, 2=store, 3=FPU).
REQ-002 Parameter NR_WB_PORTS, default 2, number of scoreboard write-back ports.
REQ-003 Parameter DEPTH, default 2, entries per source FIFO (power of two, >=2).
REQ-004 clk_i  input  1  clock; all state on rising edge.
REQ-005 rst_ni  input  1  reset; asynchronous, active-low.
REQ-006 flush_i  input  1  pipeline flush; discards all buffered results.
REQ-007 src_valid_i  input  NR_SRC  per-source result valid.
REQ-008 src_result_i  input  NR_SRC x XLEN  per-source result data.
REQ-009 src_trans_id_i  input  NR_SRC x TRANS_ID_BITS  per-source scoreboard index.
REQ-010 src_exception_i  input  NR_SRC x exception_t  per-source exception.
REQ-011 src_almost_full_o  output  NR_SRC  source FIFO holds >= DEPTH-1 entries; issue must stop that source.
REQ-012 wb_valid_o  output  NR_WB_PORTS  write-back port valid; scoreboard always accepts.
REQ-013 wb_trans_id_o / wb_result_o / wb_exception_o  output  NR_WB_PORTS x (TRANS_ID_BITS / XLEN / exception_t)  write-back payload.
REQ-014 overflow_o  output  1  sticky: a source result was dropped.

Function
REQ-015 Each source SHALL own a DEPTH-entry FIFO; src_valid_i pushes {result, trans_id, exception} at the clock edge.
REQ-016 Per cycle up to NR_WB_PORTS non-empty FIFOs SHALL be granted and popped, scanning from rr_q upward modulo NR_SRC; the k-th granted source drives port k; ungranted ports drive valid 0, payload 0.
REQ-017 rr_q SHALL update to (highest-scanned granted index + 1) mod NR_SRC when any grant occurs, else hold.
REQ-018 Baseline latency SHALL be 1 cycle: a result pushed at edge N is visible on a port no earlier than the cycle after edge N.
REQ-019 A source SHALL pop at most one entry per cycle; FIFO order per source SHALL be preserved.
REQ-020 Push to a full FIFO that is popped in the same cycle SHALL be accepted.
REQ-021 Push to a full FIFO that is not popped SHALL be dropped and set overflow_o at the next edge; overflow_o holds until reset.
REQ-022 src_almost_full_o SHALL be combinational from the FIFO count.
REQ-023 While flush_i=1: wb_valid_o forced to 0, no pops, inputs ignored; at the edge all FIFOs empty and rr_q=0; overflow_o unaffected.
REQ-024 trans_id values SHALL pass unmodified; no width conversion of result or exception.

Reset
REQ-025 On rst_ni=0: all FIFOs empty, rr_q=0, overflow_o=0, wb_valid_o=0, src_almost_full_o=0, payload outputs 0; asynchronous assertion, synchronous-safe deassertion.
REQ-026 Reset mid-operation SHALL discard all buffered entries without emitting them.

Configuration
REQ-027 Macro WB_ARBITER_BYPASS_EN: when defined, a source with an empty FIFO and src_valid_i=1 SHALL join same-cycle arbitration (0-cycle latency); if granted it is not enqueued, else it is pushed.
REQ-028 When WB_ARBITER_BYPASS_EN is undefined, only FIFO heads are arbitrated (1-cycle minimum latency, REQ-018).
REQ-029 Bypass SHALL be suppressed while flush_i=1 in both configurations.

Verification
REQ-030 Reset, then FLU push trans_id=3 result=0xDEAD -> next cycle wb_valid_o=2'b01, port0 trans_id=3, result=0xDEAD; following cycle wb_valid_o=0 (bypass off).
REQ-031 All 4 sources push in one cycle, rr_q=0 -> cycle+1 ports carry sources 0,1; cycle+2 sources 2,3; rr_q returns to 0.
REQ-032 Load source pushes 3 consecutive cycles while ports saturated by FLU/store/FPU (DEPTH=2) -> src_almost_full_o[1]=1 after first push; third push dropped, overflow_o=1 and stays 1.
REQ-033 Two entries buffered, flush_i=1 one cycle -> wb_valid_o=0 during flush and after; later push trans_id=5 emerges alone one cycle later.
REQ-034 WB_ARBITER_BYPASS_EN defined, empty FIFOs, FPU push trans_id=7 -> same cycle wb_valid_o[0]=1, trans_id=7; FIFO count stays 0.
REQ-035 Reset asserted with entries buffered -> all outputs 0 immediately; no buffered entry appears after release.
